ps2_kbd_rx: RTL and testbench
=============================

Name: ps2_kbd_rx

Overview:
- PS/2 keyboard receiver. Deserialises device-clocked PS/2 frames, checks them, and buffers good scan codes in a small FIFO.
- Sits upstream of the seven-segment display stage and feeds it the scan codes to display.
- A consumer pops one code at a time with an active-low next-data strobe.

Parameters:
- FIFO_DEPTH, 8, number of scan-code entries; power of 2, at least 2.
- TIMEOUT_CYCLES, 20000, idle clk cycles inside a frame before the partial frame is discarded; must exceed one PS/2 bit period.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- ps2_clk  in  1  raw PS/2 clock, asynchronous to clk.
- ps2_data  in  1  raw PS/2 data, asynchronous to clk.
- nextdata_n  in  1  active-low pop strobe; while low and ready=1, pops one entry per clk.
- data  out  8  scan code at the FIFO head; valid only when ready=1.
- ready  out  1  FIFO not empty.
- overflow  out  1  sticky; a good frame arrived while the FIFO was full.
- frame_err  out  1  one-cycle pulse when a completed frame fails its check.

Behaviour:
- Reset (rst=0, async):
  - FIFO emptied, pointers 0.
  - Synchronisers set to 1; shift register 0; bit_cnt 0; timeout counter 0; state IDLE.
  - Outputs: ready=0, data=0, overflow=0, frame_err=0.
  - Reset asserted mid-frame discards the partial frame.
- Synchronisation:
  - ps2_clk and ps2_data each pass through 2 flops; a third flop holds the previous ps2_clk sample.
  - fall = prev & ~cur.
  - On each cycle with fall=1, the synchronised ps2_data bit is sampled.
- Frame format, 11 bits: start(0), d0..d7 LSB first, odd parity, stop(1).
- State machine:
  - IDLE: on fall with sampled bit 0, go to RECV with bit_cnt=1. On fall with bit 1, stay in IDLE silently (no error).
  - RECV: each fall shifts in one bit and increments bit_cnt.
    - On the fall that samples bit 11 (stop), evaluate the frame in that same cycle and return to IDLE with bit_cnt=0.
    - Frame is good when stop=1 and the XOR of d0..d7 and parity is 1.
    - Good frame, FIFO not full (or a pop in the same cycle): push d[7:0] at that clk edge. ready=1 from the next cycle; latency is 1 clk after the stop-bit fall cycle.
    - Good frame, FIFO full, no same-cycle pop: drop the code and set overflow=1. FIFO contents are unchanged.
    - Bad frame: frame_err=1 for exactly the next cycle; nothing pushed.
  - Timeout: in RECV, the counter increments every clk without fall and clears on fall. On reaching TIMEOUT_CYCLES, return to IDLE with bit_cnt=0; no error pulse.
- FIFO:
  - Pointer width log2(FIFO_DEPTH)+1; wrap is natural modulo.
  - data is the registered head entry, updated on pop or on push into an empty FIFO.
  - Pop happens when nextdata_n=0 and ready=1. Pop while empty is ignored.
  - Simultaneous push and pop:
    - Not empty (including full): both happen; occupancy unchanged; no overflow.
    - Empty: only the push happens.
  - nextdata_n held low drains one entry per cycle.
- overflow clears only on reset.

Decomposition:
- Package ps2_pkg:
  - FRAME_BITS=11.
  - State enum {IDLE, RECV}.
  - Bit-position constants START_IDX=0, PARITY_IDX=9, STOP_IDX=10.
- One sub-module: ps2_fifo (parameter DEPTH, width 8). Ports: push, pop, wdata, rdata, empty, full. Same clk and active-low async rst.

Test Plan:
- Reset then an idle line, 100 cycles -> ready=0, overflow=0, frame_err=0, data=0.
- Frame 0x1C with parity 0, bit period 200 clk, then 0xF0 with parity 1, nextdata_n high -> ready=1 one cycle after the first stop fall; data=0x1C. Pulse nextdata_n low for 1 cycle -> data=0xF0. Second pulse -> ready=0.
- Frame 0x1C with parity 1 -> frame_err high for exactly 1 cycle; ready stays 0.
- Same frame 0x1C with stop=0 -> frame_err high for exactly 1 cycle; ready stays 0.
- 9 good frames 0x01..0x09, no pops -> overflow=1 after the 9th. Draining yields exactly 0x01..0x08, then ready=0.
- With FIFO full, a 10th frame whose stop-fall cycle coincides with nextdata_n=0 -> 0x0A accepted, overflow unchanged, occupancy stays 8.
- TIMEOUT_CYCLES=500: send 5 bits, idle 600 cycles, then full frame 0x32 -> data=0x32, frame_err never pulses.
- rst pulsed low after 4 bits, then full frame 0x45 -> only 0x45 received; FIFO empty before the frame.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants, state type and frame-check helper for the PS/2 receiver.
package ps2_pkg;

   localparam int FRAME_BITS = 11;
   localparam int START_IDX  = 0;
   localparam int PARITY_IDX = 9;
   localparam int STOP_IDX   = 10;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;

   // A frame is good when the stop bit is 1 and data plus parity has odd weight.
   function automatic logic frame_good(input logic [FRAME_BITS-1:0] f);
      return f[STOP_IDX] & (^f[PARITY_IDX:START_IDX+1]);
   endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Scan-code FIFO with a registered head entry presented on rdata.
module ps2_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       empty,
   output logic       full
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic [AW:0] rptr_next;
   logic [7:0]  mem [DEPTH];
   logic        do_pop;
   logic        do_push;

   assign empty     = (wptr == rptr);
   assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop    = pop & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign do_push   = push & (~full | do_pop);
   assign rptr_next = rptr + 1'b1;

   // Storage, pointers and the registered head entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         rdata <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wptr[AW-1:0]] <= wdata;
            wptr              <= wptr + 1'b1;
         end
         if (do_pop) begin
            rptr <= rptr_next;
         end
         if (do_push && empty) begin
            rdata <= wdata;
         end else if (do_pop) begin
            // With one entry left, a same-cycle push becomes the new head
            // before it has landed in the array.
            if (do_push && (rptr_next == wptr)) begin
               rdata <= wdata;
            end else begin
               rdata <= mem[rptr_next[AW-1:0]];
            end
         end
      end
   end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronise, deframe, check and buffer scan codes.
module ps2_kbd_rx
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       nextdata_n,
   output logic [7:0] data,
   output logic       ready,
   output logic       overflow,
   output logic       frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic clk_s1, clk_s2, clk_prev;
   logic data_s1, data_s2;
   logic fall;

   state_t                state_q, state_d;
   logic [3:0]            bit_cnt_q, bit_cnt_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [TW-1:0]         to_q, to_d;
   logic                  frame_done;
   logic [FRAME_BITS-1:0] frame_vec;
   logic                  good;

   logic fifo_empty, fifo_full, pop_acc;

   // Two-flop synchronisers plus the previous clock sample for edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         clk_prev <= 1'b1;
         data_s1  <= 1'b1;
         data_s2  <= 1'b1;
      end else begin
         clk_s1   <= ps2_clk;
         clk_s2   <= clk_s1;
         clk_prev <= clk_s2;
         data_s1  <= ps2_data;
         data_s2  <= data_s1;
      end
   end

   assign fall = clk_prev & ~clk_s2;

   // Receiver state, bit counter, shift register and inactivity counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         to_q      <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         to_q      <= to_d;
      end
   end

   // Next-state logic: bits shift in from the top, so after ten shifts the
   // start bit sits at index 1 and the incoming stop bit completes the frame.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      to_d       = to_q;
      frame_done = 1'b0;
      frame_vec  = {data_s2, shift_q[FRAME_BITS-1:1]};
      case (state_q)
         IDLE: begin
            to_d = '0;
            if (fall && !data_s2) begin
               state_d   = RECV;
               bit_cnt_d = 4'd1;
               shift_d   = {data_s2, shift_q[FRAME_BITS-1:1]};
            end
         end
         RECV: begin
            if (fall) begin
               to_d      = '0;
               shift_d   = {data_s2, shift_q[FRAME_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
                  frame_done = 1'b1;
                  state_d    = IDLE;
                  bit_cnt_d  = '0;
               end
            end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
               // Device went quiet mid-frame: drop the partial frame silently.
               state_d   = IDLE;
               bit_cnt_d = '0;
               to_d      = '0;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         default: begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            to_d      = '0;
         end
      endcase
   end

   assign good    = frame_done & frame_good(frame_vec);
   assign pop_acc = ~nextdata_n & ~fifo_empty;

   // Sticky overflow and the one-cycle frame error pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= frame_done & ~frame_good(frame_vec);
         if (good && fifo_full && !pop_acc) begin
            overflow <= 1'b1;
         end
      end
   end

   ps2_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (good),
      .pop   (~nextdata_n),
      .wdata (frame_vec[8:1]),
      .rdata (data),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign ready = ~fifo_empty;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed testbench for ps2_kbd_rx with immediate-assertion checks.
module tb_ps2_kbd_rx;

   logic       clk;
   logic       rst;
   logic       ps2_clk;
   logic       ps2_data;
   logic       nextdata_n;
   logic [7:0] data;
   logic       ready;
   logic       overflow;
   logic       frame_err;

   int checks   = 0;
   int failures = 0;
   int err_cnt  = 0;
   int err_base;

   ps2_kbd_rx #(
      .FIFO_DEPTH     (8),
      .TIMEOUT_CYCLES (500)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .nextdata_n (nextdata_n),
      .data       (data),
      .ready      (ready),
      .overflow   (overflow),
      .frame_err  (frame_err)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // count cycles with frame_err high
   always @(posedge clk) begin
      if (frame_err === 1'b1) err_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] mk(input logic [7:0] d, input logic par, input logic stop);
      return {stop, par, d, 1'b0};
   endfunction

   function automatic logic [10:0] good_frame(input logic [7:0] d);
      return mk(d, ~^d, 1'b1);
   endfunction

   // drive n bits; returns right after the last falling edge, ps2_clk left low
   task automatic send_bits(input logic [10:0] f, input int n, input int half);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ps2_data = f[i];
         repeat (half) @(negedge clk);
         ps2_clk = 1'b0;
         if (i != n - 1) begin
            repeat (half) @(negedge clk);
            ps2_clk = 1'b1;
         end
      end
   endtask

   task automatic finish_bit(input int half);
      repeat (half) @(negedge clk);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (half) @(negedge clk);
   endtask

   task automatic send_frame(input logic [10:0] f, input int half);
      send_bits(f, 11, half);
      finish_bit(half);
   endtask

   task automatic pop_one();
      @(negedge clk);
      nextdata_n = 1'b0;
      @(negedge clk);
      nextdata_n = 1'b1;
   endtask

   initial begin
      rst        = 1'b0;
      ps2_clk    = 1'b1;
      ps2_data   = 1'b1;
      nextdata_n = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (100) @(negedge clk);

      // reset state on an idle line
      check("rst_ready", ready, 0);
      check("rst_overflow", overflow, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_data", data, 8'h00);

      // first good frame: ready rises one clk after the stop-fall cycle
      send_bits(good_frame(8'h1C), 11, 100);
      @(posedge clk); @(posedge clk); #1;
      check("lat_ready_before", ready, 0);
      @(posedge clk); #1;
      check("lat_ready_after", ready, 1);
      check("lat_data", data, 8'h1C);
      finish_bit(100);
      send_frame(good_frame(8'hF0), 100);
      check("two_head_data", data, 8'h1C);
      pop_one();
      check("pop1_data", data, 8'hF0);
      check("pop1_ready", ready, 1);
      pop_one();
      check("pop2_ready", ready, 0);

      // bad parity
      err_base = err_cnt;
      send_bits(mk(8'h1C, 1'b1, 1'b1), 11, 100);
      @(posedge clk); @(posedge clk); #1;
      check("par_err_pre", frame_err, 0);
      @(posedge clk); #1;
      check("par_err_pulse", frame_err, 1);
      @(posedge clk); #1;
      check("par_err_post", frame_err, 0);
      finish_bit(100);
      check("par_err_count", err_cnt - err_base, 1);
      check("par_ready", ready, 0);

      // bad stop bit
      err_base = err_cnt;
      send_bits(mk(8'h1C, 1'b0, 1'b0), 11, 100);
      @(posedge clk); @(posedge clk); #1;
      check("stop_err_pre", frame_err, 0);
      @(posedge clk); #1;
      check("stop_err_pulse", frame_err, 1);
      @(posedge clk); #1;
      check("stop_err_post", frame_err, 0);
      finish_bit(100);
      check("stop_err_count", err_cnt - err_base, 1);
      check("stop_ready", ready, 0);

      // overflow: nine frames into eight slots
      for (int k = 1; k <= 9; k++) begin
         send_frame(good_frame(8'(k)), 100);
         if (k == 8) check("ovf_after8", overflow, 0);
      end
      check("ovf_after9", overflow, 1);
      for (int k = 1; k <= 8; k++) begin
         check("drain_ready", ready, 1);
         check("drain_data", data, 32'(k));
         pop_one();
      end
      check("drain_empty", ready, 0);
      check("ovf_sticky", overflow, 1);

      // refill, then push into a full FIFO with a same-cycle pop
      for (int k = 0; k < 8; k++) begin
         send_frame(good_frame(8'h11 + 8'(k)), 20);
      end
      check("refill_head", data, 8'h11);
      send_bits(good_frame(8'h0A), 11, 20);
      @(negedge clk);
      @(negedge clk);
      nextdata_n = 1'b0;
      @(negedge clk);
      nextdata_n = 1'b1;
      finish_bit(20);
      check("full_pop_ovf", overflow, 1);
      check("full_pop_head", data, 8'h12);
      for (int k = 0; k < 7; k++) begin
         check("full_drain_data", data, 32'h12 + 32'(k));
         pop_one();
      end
      check("full_last_ready", ready, 1);
      check("full_last_data", data, 8'h0A);
      pop_one();
      check("full_drain_empty", ready, 0);

      // timeout discards a partial frame without an error
      err_base = err_cnt;
      send_bits(good_frame(8'h32), 5, 100);
      repeat (100) @(negedge clk);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (600) @(negedge clk);
      send_frame(good_frame(8'h32), 100);
      check("to_ready", ready, 1);
      check("to_data", data, 8'h32);
      check("to_no_err", err_cnt - err_base, 0);
      pop_one();
      check("to_empty", ready, 0);

      // reset mid-frame
      send_bits(good_frame(8'h45), 4, 100);
      repeat (100) @(negedge clk);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_rst_ovf", overflow, 0);
      check("mid_rst_ready", ready, 0);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      err_base = err_cnt;
      send_frame(good_frame(8'h45), 100);
      check("mid_rst_data", data, 8'h45);
      check("mid_rst_rdy", ready, 1);
      check("mid_rst_no_err", err_cnt - err_base, 0);
      pop_one();
      check("mid_rst_single", ready, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
